// File: rtl/hni_txrsp_pkg.sv
// ---------------------------------------------------------------------------
// hni_txrsp_pkg : shared constants, flit layout and FSM states for HN-I TXRSP
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hni_txrsp_pkg;

  localparam int CHIE_RSP_FLIT_WIDTH   = 65;
  localparam int CHIE_RSP_OPCODE_LSB   = 38;
  localparam int CHIE_RSP_OPCODE_WIDTH = 5;

  localparam logic [CHIE_RSP_OPCODE_WIDTH-1:0] RSP_LCRD_RETURN = 5'h00;
  localparam int HNI_LL_CRD_INCDEC_ONE = 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_RETURN = 2'b10,
    ST_STOP   = 2'b11
  } txrsp_state_e;

  // Credit-return flit: every field zero except the opcode.
  function automatic logic [CHIE_RSP_FLIT_WIDTH-1:0] lcrd_return_flit();
    logic [CHIE_RSP_FLIT_WIDTH-1:0] f;
    f = '0;
    f[CHIE_RSP_OPCODE_LSB +: CHIE_RSP_OPCODE_WIDTH] = RSP_LCRD_RETURN;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hni_txrsp_fifo.sv
// ---------------------------------------------------------------------------
// hni_txrsp_fifo : synchronous FIFO with occupancy count, head-of-queue output
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hni_txrsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int                 C_PTR_W   = $clog2(DEPTH);
  localparam logic [C_PTR_W:0]   C_DEPTH   = (C_PTR_W+1)'(DEPTH);
  localparam logic [C_PTR_W:0]   C_CNT_ONE = (C_PTR_W+1)'(1);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == C_DEPTH);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      if (w_do_push && !w_do_pop)      r_count <= r_count + C_CNT_ONE;
      else if (w_do_pop && !w_do_push) r_count <= r_count - C_CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hni_txrsp.sv
// ---------------------------------------------------------------------------
// hni_txrsp : CHI-E TX response link layer of the HN-I (queue, credits, FSM)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hni_txrsp
  import hni_txrsp_pkg::*;
#(
  parameter int TXRSP_FIFO_DEPTH         = 4,
  parameter int XP_LCRD_NUM_PARAM        = 15,
  parameter int HNI_LL_RSP_CRD_CNT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           txrsp_lcrdv,
  input  logic                           txlink_active,
  input  logic                           txrsp_req_valid_s0,
  input  logic [CHIE_RSP_FLIT_WIDTH-1:0] txrsp_req_flit_s0,
  output logic                           txrsp_req_ready,
  output logic                           txrspflitv,
  output logic [CHIE_RSP_FLIT_WIDTH-1:0] txrspflit,
  output logic                           txrspflitpend,
  output logic                           txrsp_crd_returned,
  output logic                           txrsp_crd_ovf_err
);

  localparam int C_CW    = HNI_LL_RSP_CRD_CNT_WIDTH;
  localparam int C_CNT_W = $clog2(TXRSP_FIFO_DEPTH) + 1;
  localparam logic [C_CW-1:0]    C_CRD_MAX  = C_CW'(XP_LCRD_NUM_PARAM);
  localparam logic [C_CW-1:0]    C_CRD_ONE  = C_CW'(HNI_LL_CRD_INCDEC_ONE);
  localparam logic [C_CNT_W-1:0] C_FIFO_ONE = C_CNT_W'(1);

  txrsp_state_e                 r_state;
  txrsp_state_e                 w_state_nxt;
  logic [C_CW-1:0]              r_crd;
  logic                         r_flitv;
  logic [CHIE_RSP_FLIT_WIDTH-1:0] r_flit;
  logic                         r_flitpend;
  logic                         r_ovf;

  logic                         w_push;
  logic                         w_pop;
  logic                         w_send;
  logic                         w_src_lcrd;
  logic                         w_crd_avail;
  logic                         w_fifo_nonempty_nxt;
  logic [CHIE_RSP_FLIT_WIDTH-1:0] w_fifo_head;
  logic [C_CNT_W-1:0]           w_fifo_cnt;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;

  hni_txrsp_fifo #(
    .DEPTH (TXRSP_FIFO_DEPTH),
    .WIDTH (CHIE_RSP_FLIT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (txrsp_req_flit_s0),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .count     (w_fifo_cnt),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // Ready depends only on registered state, so a same-cycle pop never frees a slot.
  assign txrsp_req_ready    = ~w_fifo_full & (r_state == ST_RUN);
  assign w_push             = txrsp_req_valid_s0 & txrsp_req_ready;
  assign w_crd_avail        = (r_crd != '0);
  assign w_pop              = w_send & ~w_src_lcrd;
  assign w_fifo_nonempty_nxt = w_push | (w_fifo_cnt > C_FIFO_ONE) | (~w_fifo_empty & ~w_pop);

  always_comb begin
    w_send     = 1'b0;
    w_src_lcrd = 1'b0;
    case (r_state)
      ST_RUN, ST_DRAIN: w_send = w_crd_avail & ~w_fifo_empty;
      ST_RETURN: begin
        w_send     = w_crd_avail;
        w_src_lcrd = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (!txlink_active) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_fifo_empty) w_state_nxt = ST_RETURN;
      ST_RETURN: if (!w_crd_avail && !txrsp_lcrdv) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (txlink_active)    w_state_nxt = ST_RUN;
        else if (w_crd_avail) w_state_nxt = ST_RETURN;
      end
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_crd      <= '0;
      r_flitv    <= 1'b0;
      r_flit     <= '0;
      r_flitpend <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_flitv    <= w_send;
      r_flit     <= w_send ? (w_src_lcrd ? lcrd_return_flit() : w_fifo_head) : '0;
      r_flitpend <= w_fifo_nonempty_nxt | (w_state_nxt == ST_RETURN);
      // A grant and a send in the same cycle cancel out.
      if (txrsp_lcrdv && !w_send) begin
        if (r_crd == C_CRD_MAX) r_ovf <= 1'b1;
        else                    r_crd <= r_crd + C_CRD_ONE;
      end else if (w_send && !txrsp_lcrdv) begin
        r_crd <= r_crd - C_CRD_ONE;
      end
    end
  end

  assign txrspflitv         = r_flitv;
  assign txrspflit          = r_flit;
  assign txrspflitpend      = r_flitpend;
  assign txrsp_crd_ovf_err  = r_ovf;
  assign txrsp_crd_returned = (r_state == ST_STOP) & ~w_crd_avail;

endmodule

`default_nettype wire

// File: tb/tb_hni_txrsp.sv
// ---------------------------------------------------------------------------
// tb_hni_txrsp : randomized self-checking bench for hni_txrsp
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hni_txrsp;
  import hni_txrsp_pkg::*;

  localparam int FW    = CHIE_RSP_FLIT_WIDTH;
  localparam int DEPTH = 4;
  localparam int CEIL  = 15;
  localparam int M_RUN = 0, M_DRAIN = 1, M_RETURN = 2, M_STOP = 3;

  typedef logic [FW-1:0] flit_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  lcrdv = 1'b0;
  logic  link_active = 1'b1;
  logic  req_valid = 1'b0;
  flit_t req_flit = '0;
  logic  ready, flitv, flitpend, crd_returned, ovf;
  flit_t flit;

  always #5 clk = ~clk;

  hni_txrsp #(
    .TXRSP_FIFO_DEPTH         (DEPTH),
    .XP_LCRD_NUM_PARAM        (CEIL),
    .HNI_LL_RSP_CRD_CNT_WIDTH (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .txrsp_lcrdv        (lcrdv),
    .txlink_active      (link_active),
    .txrsp_req_valid_s0 (req_valid),
    .txrsp_req_flit_s0  (req_flit),
    .txrsp_req_ready    (ready),
    .txrspflitv         (flitv),
    .txrspflit          (flit),
    .txrspflitpend      (flitpend),
    .txrsp_crd_returned (crd_returned),
    .txrsp_crd_ovf_err  (ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: response queue, credit count, link mode, expected outputs.
  flit_t mq[$];
  int    m_crd;
  int    m_mode;
  bit    m_flitv, m_pend, m_ovf;
  flit_t m_flit;

  task automatic chk(input string tag, input flit_t got, input flit_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_crd = 0; m_mode = M_RUN;
    m_flitv = 0; m_flit = '0; m_pend = 0; m_ovf = 0;
  endfunction

  function automatic void model_step(bit v, flit_t f, bit l, bit a);
    bit rdy, acc, snd, q_empty_pre;
    int crd_pre, nxt;
    rdy = (mq.size() != DEPTH) && (m_mode == M_RUN);
    acc = v && rdy;
    q_empty_pre = (mq.size() == 0);
    crd_pre = m_crd;
    snd = (crd_pre > 0) && ((m_mode == M_RETURN) ||
          ((m_mode == M_RUN || m_mode == M_DRAIN) && !q_empty_pre));
    m_flitv = snd;
    // A credit-return flit has opcode 0 and all other fields 0.
    m_flit  = !snd ? '0 : (m_mode == M_RETURN) ? '0 : mq[0];
    if (snd && m_mode != M_RETURN) void'(mq.pop_front());
    if (acc) mq.push_back(f);
    if (l && !snd) begin
      if (m_crd == CEIL) m_ovf = 1;
      else m_crd++;
    end else if (snd && !l) m_crd--;
    nxt = m_mode;
    case (m_mode)
      M_RUN:    if (!a) nxt = M_DRAIN;
      M_DRAIN:  if (q_empty_pre) nxt = M_RETURN;
      M_RETURN: if (crd_pre == 0 && !l) nxt = M_STOP;
      default:  if (a) nxt = M_RUN; else if (crd_pre != 0) nxt = M_RETURN;
    endcase
    m_mode = nxt;
    m_pend = (mq.size() != 0) || (m_mode == M_RETURN);
  endfunction

  task automatic check_outputs();
    chk("flitv", flitv, m_flitv);
    chk("flit", flit, m_flit);
    chk("flitpend", flitpend, m_pend);
    chk("ovf_err", ovf, m_ovf);
    chk("ready", ready, (mq.size() != DEPTH) && (m_mode == M_RUN));
    chk("crd_returned", crd_returned, (m_mode == M_STOP) && (m_crd == 0));
  endtask

  function automatic flit_t rnd_flit();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  // Called at a falling edge: drive, clock, advance model, then compare.
  task automatic cycle(input bit v, input flit_t f, input bit l, input bit a);
    req_valid = v; req_flit = f; lcrdv = l; link_active = a;
    @(posedge clk);
    model_step(v, f, l, a);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 1);
  endtask

  task automatic do_reset();
    req_valid = 0; lcrdv = 0; link_active = 1;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1;
  endtask

  task automatic deactivate_round();
    int k;
    k = 0;
    while (!crd_returned && k < 200) begin
      cycle($urandom_range(0, 1), rnd_flit(), ($urandom_range(0, 5) == 0), 0);
      k++;
    end
    chk("drain_done", crd_returned, 1);
    cycle(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single flit held back until a credit arrives.
    idle(1);
    cycle(1, rnd_flit(), 0, 1);
    idle(3);
    cycle(0, '0, 1, 1);
    idle(4);

    // Two credits against four queued flits, then two more credits.
    repeat (2) cycle(0, '0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(1, rnd_flit(), 0, 1);
    idle(3);
    repeat (2) cycle(0, '0, 1, 1);
    idle(4);

    // Grant coinciding with a send keeps the count steady.
    repeat (2) cycle(1, rnd_flit(), 0, 1);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 1, 1);
    idle(3);

    // Full FIFO refuses a fifth request; a credit frees one slot.
    for (int i = 0; i < 5; i++) cycle(1, rnd_flit(), 0, 1);
    cycle(1, rnd_flit(), 1, 1);
    idle(3);
    repeat (4) cycle(0, '0, 1, 1);
    idle(4);

    // Deactivation with three credits and one queued flit.
    repeat (3) cycle(0, '0, 1, 1);
    cycle(1, rnd_flit(), 0, 1);
    deactivate_round();

    // Randomized traffic with periodic link deactivation.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 150; i++)
        cycle($urandom_range(0, 1), rnd_flit(), ($urandom_range(0, 2) == 0), 1);
      deactivate_round();
    end

    // Credit flood beyond the ceiling.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 17; i++) cycle(0, '0, 1, 1);
    idle(2);

    // Reset in the middle of traffic discards queue and credits.
    for (int i = 0; i < 4; i++) cycle(1, rnd_flit(), (i > 0), 1);
    do_reset();
    cycle(0, '0, 1, 1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/hni_txrsp.md
Name: hni_txrsp

Overview:
- CHI-E TX response channel of the HN-I.
- Accepts response flits from hni_mshr into a small FIFO and holds the link-layer credits granted by the XP via txrsp_lcrdv.
- Launches one flit per cycle on the TXRSP link when a credit is held, and asserts flitpend ahead of flitv.
- On link deactivation, drains queued responses, then returns every held credit using RespLCrdReturn flits.

Parameters:
- TXRSP_FIFO_DEPTH, 4, number of response entries buffered; power of two, at least 2.
- XP_LCRD_NUM_PARAM, 15, maximum link credits the XP can grant; sets the credit counter ceiling.
- HNI_LL_RSP_CRD_CNT_WIDTH, 4, credit counter width; must satisfy 2^width > XP_LCRD_NUM_PARAM.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- txrsp_lcrdv  in  1  one link credit granted by the XP this cycle.
- txlink_active  in  1  1 = link in RUN; 0 = deactivation requested.
- txrsp_req_valid_s0  in  1  hni_mshr presents a response flit.
- txrsp_req_flit_s0  in  CHIE_RSP_FLIT_WIDTH  response flit from hni_mshr.
- txrsp_req_ready  out  1  FIFO can accept; combinational from registered occupancy.
- txrspflitv  out  1  flit valid on the link; registered.
- txrspflit  out  CHIE_RSP_FLIT_WIDTH  flit on the link; registered; all zeros when txrspflitv=0.
- txrspflitpend  out  1  flit pending; registered.
- txrsp_crd_returned  out  1  idle after deactivation: FIFO empty and credits 0.
- txrsp_crd_ovf_err  out  1  sticky; credit received at ceiling.

Behaviour:
- Reset values (rst_n=0, asynchronous): FIFO empty, credit count 0, state RUN.
- Outputs during reset: txrspflitv=0, txrspflit=0, txrspflitpend=0, txrsp_crd_ovf_err=0, txrsp_crd_returned=0, txrsp_req_ready=1.
- Reset mid-operation discards queued flits and held credits. No flit is emitted in the cycle after rst_n rises.
- Accept: push occurs when txrsp_req_valid_s0 & txrsp_req_ready.
  - txrsp_req_ready = (count != DEPTH) & (state == RUN).
  - No bypass: with the FIFO full, a same-cycle pop does not raise ready.
- Send condition, evaluated in cycle N: credit count (registered) != 0 and a flit source is available.
  - In RUN or DRAIN, the source is the FIFO head (FIFO non-empty).
  - In RETURN, the source is a RespLCrdReturn flit: all fields zero except Opcode = RespLCrdReturn (`CHIE_RSP_FLIT_OPCODE_RANGE` = 0).
  - When the condition holds, the head is popped (FIFO source) and txrspflitv/txrspflit are high in cycle N+1.
- Latency: a request accepted in cycle N appears on txrspflitv no earlier than N+2, provided a credit is held.
- Credit counter update:
  - lcrdv only: +1.
  - send only: -1.
  - both in the same cycle: unchanged.
  - A credit arriving in cycle N is usable in N+1.
- Credit ceiling: lcrdv while count == XP_LCRD_NUM_PARAM and no send that cycle leaves the count unchanged and sets txrsp_crd_ovf_err (cleared only by reset).
- txrspflitpend_q <= (FIFO non-empty after this cycle's push/pop) | (next state == RETURN).
  - Consequence: flitpend is high in the cycle before any flitv.
- States:
  - RUN: normal accept and send. If txlink_active=0, go to DRAIN.
  - DRAIN: no accepts; send queued flits. When FIFO empty (registered), go to RETURN.
  - RETURN: send one RespLCrdReturn per held credit, one per cycle. A credit arriving during RETURN is also returned. When count==0 and no lcrdv this cycle, go to STOP.
  - STOP: txrsp_crd_returned=1, no sends. Credits still accumulate; any nonzero count goes back to RETURN. If txlink_active=1, go to RUN.
- txlink_active rising again while in DRAIN or RETURN is ignored until STOP is reached.
- No backpressure exists on the link: a sent flit is never held or retried.

Decomposition:
- hni_defines: RespLCrdReturn opcode constant, HNI_LL_CRD_INCDEC_ONE, state encodings (RUN=2'b00, DRAIN=2'b01, RETURN=2'b10, STOP=2'b11).
- Flit field ranges come from chie_defines.
- One sub-module: hni_txrsp_fifo, a parameterised synchronous FIFO with push/pop/count/full/empty and asynchronous active-low reset.
- Credit logic and the FSM stay in hni_txrsp.

Test Plan:
- Reset release, push flit A at cycle 2, no credits → txrspflitpend=1 from cycle 3, txrspflitv never asserts; txrsp_lcrdv at cycle 6 → flit A on the link in cycle 8; credit count 0 in cycle 9.
- Grant 2 credits, push 4 flits back-to-back → exactly 2 flits sent in consecutive cycles; grant 2 more → remaining 2 sent in order; FIFO empty, flitpend falls.
- Credit count 1, lcrdv and send in the same cycle → count stays 1; the next queued flit goes out in the following cycle.
- Fill 4 entries with 0 credits → txrsp_req_ready=0, and a 5th valid is not accepted. Grant 1 credit → ready returns 1 only after the count drops to 3.
- Hold 3 credits with 1 queued flit, drop txlink_active → queued flit sent, then 2 RespLCrdReturn flits (opcode 0) in 2 cycles; txrsp_crd_returned=1 afterwards; ready=0 throughout.
- Grant 16 credits with no traffic (ceiling 15) → count saturates at 15 and txrsp_crd_ovf_err=1 sticky. Assert rst_n=0 mid-stream → all outputs zero immediately, count 0.
